// File: rtl/ftdi_fifo_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | Module   : ftdi_fifo_arbiter_if                                          |
// | Purpose  : Requester/arbiter handshake bundle for the FTDI FIFO arbiter.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

interface ftdi_fifo_arbiter_if;
    logic iRD_REQ;
    logic iWR_REQ;
    logic iRD_DONE_n;
    logic iWR_DONE_n;
    logic iFIFO_RXF_n;
    logic iFIFO_TXE_n;
    logic oRD_GNT;
    logic oWR_GNT;
    logic oBUS_OE;
    logic oBUSY;

    // Requester/FTDI side drives requests and flags, sees the grants.
    modport master (
        output iRD_REQ, iWR_REQ, iRD_DONE_n, iWR_DONE_n, iFIFO_RXF_n, iFIFO_TXE_n,
        input  oRD_GNT, oWR_GNT, oBUS_OE, oBUSY
    );

    modport slave (
        input  iRD_REQ, iWR_REQ, iRD_DONE_n, iWR_DONE_n, iFIFO_RXF_n, iFIFO_TXE_n,
        output oRD_GNT, oWR_GNT, oBUS_OE, oBUSY
    );
endinterface

`default_nettype wire

// File: rtl/ftdi_fifo_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module   : ftdi_fifo_arbiter                                             |
// | Purpose  : Round-robin read/write owner arbiter for a shared FTDI FIFO   |
// |            bus. Optional burst limiting: FTDI_FIFO_ARBITER_BURST_EN.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module ftdi_fifo_arbiter #(
    parameter int MAX_BURST   = 8,
    parameter int TURN_CYCLES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ftdi_fifo_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_OWN = 2'd1,
        WR_OWN = 2'd2,
        TURN   = 2'd3
    } state_t;

    localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);

    state_t     state_q, state_d;
    logic       last_wr_q, last_wr_d;
    logic [3:0] turn_q, turn_d;
    logic       rd_gnt_q, wr_gnt_q, bus_oe_q, busy_q;

    logic w_rd_elig, w_wr_elig;
    logic w_own_req, w_own_done;

    assign w_rd_elig  = bus.iRD_REQ & ~bus.iFIFO_RXF_n;
    assign w_wr_elig  = bus.iWR_REQ & ~bus.iFIFO_TXE_n;
    // Only the current owner's request and DONE pulse matter in an OWN state.
    assign w_own_req  = (state_q == WR_OWN) ? bus.iWR_REQ     : bus.iRD_REQ;
    assign w_own_done = (state_q == WR_OWN) ? ~bus.iWR_DONE_n : ~bus.iRD_DONE_n;

`ifdef FTDI_FIFO_ARBITER_BURST_EN
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    logic [7:0] burst_q, burst_d;
    logic [7:0] w_burst_inc;
    logic       w_other_elig;

    assign w_burst_inc  = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
    assign w_other_elig = (state_q == WR_OWN) ? w_rd_elig : w_wr_elig;
`endif

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        turn_d    = turn_q;
`ifdef FTDI_FIFO_ARBITER_BURST_EN
        burst_d   = burst_q;
`endif
        case (state_q)
            IDLE: begin
                // Read wins a tie only when write was served last.
                if (w_rd_elig && (!w_wr_elig || last_wr_q)) begin
                    state_d   = RD_OWN;
                    last_wr_d = 1'b0;
`ifdef FTDI_FIFO_ARBITER_BURST_EN
                    burst_d   = 8'd0;
`endif
                end else if (w_wr_elig) begin
                    state_d   = WR_OWN;
                    last_wr_d = 1'b1;
`ifdef FTDI_FIFO_ARBITER_BURST_EN
                    burst_d   = 8'd0;
`endif
                end
            end
            RD_OWN, WR_OWN: begin
`ifdef FTDI_FIFO_ARBITER_BURST_EN
                if (w_own_done) begin
                    burst_d = w_burst_inc;
                end
                // Past the limit with nobody waiting, the owner keeps the bus;
                // the next DONE once the other side is waiting releases it.
                if (!w_own_req ||
                    (w_own_done && (w_burst_inc >= BURST_MAX) && w_other_elig)) begin
                    state_d = TURN;
                    turn_d  = 4'd0;
                end
`else
                if (!w_own_req || w_own_done) begin
                    state_d = TURN;
                    turn_d  = 4'd0;
                end
`endif
            end
            TURN: begin
                if (turn_q == TURN_LAST) begin
                    state_d = IDLE;
                    turn_d  = 4'd0;
                end else begin
                    turn_d  = turn_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                turn_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b1;
            turn_q    <= 4'd0;
            rd_gnt_q  <= 1'b0;
            wr_gnt_q  <= 1'b0;
            bus_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef FTDI_FIFO_ARBITER_BURST_EN
            burst_q   <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            turn_q    <= turn_d;
            rd_gnt_q  <= (state_d == RD_OWN);
            wr_gnt_q  <= (state_d == WR_OWN);
            bus_oe_q  <= (state_d == WR_OWN);
            busy_q    <= (state_d != IDLE);
`ifdef FTDI_FIFO_ARBITER_BURST_EN
            burst_q   <= burst_d;
`endif
        end
    end

    assign bus.oRD_GNT = rd_gnt_q;
    assign bus.oWR_GNT = wr_gnt_q;
    assign bus.oBUS_OE = bus_oe_q;
    assign bus.oBUSY   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ftdi_fifo_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_ftdi_fifo_arbiter                                          |
// | Purpose  : Directed self-checking bench for ftdi_fifo_arbiter.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ftdi_fifo_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ftdi_fifo_arbiter_if bus_if ();

    ftdi_fifo_arbiter #(
        .MAX_BURST   (8),
        .TURN_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.iRD_REQ     = 1'b0;
        bus_if.iWR_REQ     = 1'b0;
        bus_if.iRD_DONE_n  = 1'b1;
        bus_if.iWR_DONE_n  = 1'b1;
        bus_if.iFIFO_RXF_n = 1'b1;
        bus_if.iFIFO_TXE_n = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic pulse_rd();
        bus_if.iRD_DONE_n = 1'b0;
        tick();
        bus_if.iRD_DONE_n = 1'b1;
    endtask

    task automatic pulse_wr();
        bus_if.iWR_DONE_n = 1'b0;
        tick();
        bus_if.iWR_DONE_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        bus_if.iRD_REQ = 1'b1; bus_if.iFIFO_RXF_n = 1'b0;
        bus_if.iWR_REQ = 1'b1; bus_if.iFIFO_TXE_n = 1'b0;
        tick(); tick(); tick();
        checks++; if (bus_if.oRD_GNT !== 1'b0) begin errors++; $display("FAIL reset_rd_gnt got %b want 0", bus_if.oRD_GNT); end
        checks++; if (bus_if.oWR_GNT !== 1'b0) begin errors++; $display("FAIL reset_wr_gnt got %b want 0", bus_if.oWR_GNT); end
        checks++; if (bus_if.oBUS_OE !== 1'b0) begin errors++; $display("FAIL reset_bus_oe got %b want 0", bus_if.oBUS_OE); end
        checks++; if (bus_if.oBUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus_if.oBUSY); end
    endtask

    task automatic test_first_tie();
        rst = 1'b1;
        tick();
        checks++; if (bus_if.oRD_GNT !== 1'b1) begin errors++; $display("FAIL tie_rd_gnt got %b want 1", bus_if.oRD_GNT); end
        checks++; if (bus_if.oWR_GNT !== 1'b0) begin errors++; $display("FAIL tie_wr_gnt got %b want 0", bus_if.oWR_GNT); end
        checks++; if (bus_if.oBUS_OE !== 1'b0) begin errors++; $display("FAIL tie_bus_oe got %b want 0", bus_if.oBUS_OE); end
        checks++; if (bus_if.oBUSY !== 1'b1) begin errors++; $display("FAIL tie_busy got %b want 1", bus_if.oBUSY); end
    endtask

    // Both sides stay eligible: RD, TURN x2, IDLE, WR, TURN x2, IDLE, RD.
    task automatic test_alternate();
        do_reset();
        bus_if.iRD_REQ = 1'b1; bus_if.iFIFO_RXF_n = 1'b0;
        bus_if.iWR_REQ = 1'b1; bus_if.iFIFO_TXE_n = 1'b0;
        tick();
        checks++; if (bus_if.oRD_GNT !== 1'b1) begin errors++; $display("FAIL alt_rd_first got %b want 1", bus_if.oRD_GNT); end
        pulse_wr();
        checks++; if (bus_if.oRD_GNT !== 1'b1) begin errors++; $display("FAIL alt_nonowner_done got rd_gnt %b want 1", bus_if.oRD_GNT); end
        pulse_rd();
        checks++; if ({bus_if.oRD_GNT, bus_if.oWR_GNT, bus_if.oBUSY} !== 3'b001) begin errors++; $display("FAIL alt_turn1 got rd/wr/busy %b want 001", {bus_if.oRD_GNT, bus_if.oWR_GNT, bus_if.oBUSY}); end
        tick();
        checks++; if ({bus_if.oRD_GNT, bus_if.oWR_GNT, bus_if.oBUSY} !== 3'b001) begin errors++; $display("FAIL alt_turn2 got rd/wr/busy %b want 001", {bus_if.oRD_GNT, bus_if.oWR_GNT, bus_if.oBUSY}); end
        tick();
        checks++; if ({bus_if.oRD_GNT, bus_if.oWR_GNT, bus_if.oBUSY} !== 3'b000) begin errors++; $display("FAIL alt_idle got rd/wr/busy %b want 000", {bus_if.oRD_GNT, bus_if.oWR_GNT, bus_if.oBUSY}); end
        tick();
        checks++; if ({bus_if.oRD_GNT, bus_if.oWR_GNT, bus_if.oBUS_OE} !== 3'b011) begin errors++; $display("FAIL alt_wr_grant got rd/wr/oe %b want 011", {bus_if.oRD_GNT, bus_if.oWR_GNT, bus_if.oBUS_OE}); end
        pulse_rd();
        checks++; if (bus_if.oWR_GNT !== 1'b1) begin errors++; $display("FAIL alt_nonowner_done_wr got wr_gnt %b want 1", bus_if.oWR_GNT); end
        pulse_wr();
        checks++; if ({bus_if.oWR_GNT, bus_if.oBUS_OE, bus_if.oBUSY} !== 3'b001) begin errors++; $display("FAIL alt_wr_release got wr/oe/busy %b want 001", {bus_if.oWR_GNT, bus_if.oBUS_OE, bus_if.oBUSY}); end
        tick();
        checks++; if (bus_if.oBUSY !== 1'b1) begin errors++; $display("FAIL alt_turn_b2 got busy %b want 1", bus_if.oBUSY); end
        tick();
        checks++; if (bus_if.oBUSY !== 1'b0) begin errors++; $display("FAIL alt_idle_b got busy %b want 0", bus_if.oBUSY); end
        tick();
        checks++; if ({bus_if.oRD_GNT, bus_if.oWR_GNT, bus_if.oBUS_OE} !== 3'b100) begin errors++; $display("FAIL alt_rd_again got rd/wr/oe %b want 100", {bus_if.oRD_GNT, bus_if.oWR_GNT, bus_if.oBUS_OE}); end
    endtask

`ifdef FTDI_FIFO_ARBITER_BURST_EN
    task automatic test_burst_release();
        do_reset();
        bus_if.iRD_REQ = 1'b1; bus_if.iFIFO_RXF_n = 1'b0;
        bus_if.iWR_REQ = 1'b1; bus_if.iFIFO_TXE_n = 1'b0;
        tick();
        for (int i = 1; i <= 7; i++) begin
            pulse_rd();
            checks++; if (bus_if.oRD_GNT !== 1'b1) begin errors++; $display("FAIL burst_hold pulse %0d got rd_gnt %b want 1", i, bus_if.oRD_GNT); end
        end
        pulse_rd();
        checks++; if ({bus_if.oRD_GNT, bus_if.oBUSY} !== 2'b01) begin errors++; $display("FAIL burst_release got rd/busy %b want 01", {bus_if.oRD_GNT, bus_if.oBUSY}); end
        tick();
        checks++; if (bus_if.oBUSY !== 1'b1) begin errors++; $display("FAIL burst_turn2 got busy %b want 1", bus_if.oBUSY); end
        tick();
        checks++; if ({bus_if.oWR_GNT, bus_if.oBUSY} !== 2'b00) begin errors++; $display("FAIL burst_idle got wr/busy %b want 00", {bus_if.oWR_GNT, bus_if.oBUSY}); end
        tick();
        checks++; if ({bus_if.oWR_GNT, bus_if.oBUS_OE} !== 2'b11) begin errors++; $display("FAIL burst_wr_grant got wr/oe %b want 11", {bus_if.oWR_GNT, bus_if.oBUS_OE}); end
    endtask

    task automatic test_burst_alone();
        do_reset();
        bus_if.iWR_REQ = 1'b1; bus_if.iFIFO_TXE_n = 1'b0;
        tick();
        for (int i = 1; i <= 20; i++) begin
            pulse_wr();
            checks++; if (bus_if.oWR_GNT !== 1'b1) begin errors++; $display("FAIL burst_alone pulse %0d got wr_gnt %b want 1", i, bus_if.oWR_GNT); end
        end
    endtask
`endif

    // DONE and REQ drop together: one TURN, then stays IDLE.
    task automatic test_single_release();
        do_reset();
        bus_if.iRD_REQ = 1'b1; bus_if.iFIFO_RXF_n = 1'b0;
        tick();
        checks++; if (bus_if.oRD_GNT !== 1'b1) begin errors++; $display("FAIL single_grant got %b want 1", bus_if.oRD_GNT); end
        bus_if.iRD_DONE_n = 1'b0;
        bus_if.iRD_REQ    = 1'b0;
        tick();
        bus_if.iRD_DONE_n = 1'b1;
        checks++; if ({bus_if.oRD_GNT, bus_if.oBUSY} !== 2'b01) begin errors++; $display("FAIL single_turn1 got rd/busy %b want 01", {bus_if.oRD_GNT, bus_if.oBUSY}); end
        tick();
        checks++; if (bus_if.oBUSY !== 1'b1) begin errors++; $display("FAIL single_turn2 got busy %b want 1", bus_if.oBUSY); end
        tick();
        checks++; if (bus_if.oBUSY !== 1'b0) begin errors++; $display("FAIL single_idle got busy %b want 0", bus_if.oBUSY); end
        tick();
        checks++; if ({bus_if.oRD_GNT, bus_if.oBUSY} !== 2'b00) begin errors++; $display("FAIL single_stay_idle got rd/busy %b want 00", {bus_if.oRD_GNT, bus_if.oBUSY}); end
    endtask

    task automatic test_flag_hold();
        do_reset();
        bus_if.iWR_REQ = 1'b1; bus_if.iFIFO_TXE_n = 1'b0;
        tick();
        bus_if.iFIFO_TXE_n = 1'b1;
        tick(); tick(); tick();
        checks++; if ({bus_if.oWR_GNT, bus_if.oBUS_OE} !== 2'b11) begin errors++; $display("FAIL flag_hold got wr/oe %b want 11", {bus_if.oWR_GNT, bus_if.oBUS_OE}); end
        bus_if.iWR_REQ = 1'b0;
        tick();
        checks++; if ({bus_if.oWR_GNT, bus_if.oBUS_OE, bus_if.oBUSY} !== 3'b001) begin errors++; $display("FAIL flag_req_drop got wr/oe/busy %b want 001", {bus_if.oWR_GNT, bus_if.oBUS_OE, bus_if.oBUSY}); end
    endtask

    task automatic test_txe_wait();
        do_reset();
        bus_if.iWR_REQ = 1'b1; bus_if.iFIFO_TXE_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({bus_if.oWR_GNT, bus_if.oBUSY} !== 2'b00) begin errors++; $display("FAIL txe_wait cycle %0d got wr/busy %b want 00", i, {bus_if.oWR_GNT, bus_if.oBUSY}); end
        end
        bus_if.iFIFO_TXE_n = 1'b0;
        tick();
        checks++; if ({bus_if.oWR_GNT, bus_if.oBUS_OE} !== 2'b11) begin errors++; $display("FAIL txe_grant got wr/oe %b want 11", {bus_if.oWR_GNT, bus_if.oBUS_OE}); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b0;
        tick();
        checks++; if ({bus_if.oRD_GNT, bus_if.oWR_GNT, bus_if.oBUS_OE, bus_if.oBUSY} !== 4'b0000) begin errors++; $display("FAIL mid_reset got rd/wr/oe/busy %b want 0000", {bus_if.oRD_GNT, bus_if.oWR_GNT, bus_if.oBUS_OE, bus_if.oBUSY}); end
        rst = 1'b1;
        bus_if.iRD_REQ = 1'b1; bus_if.iFIFO_RXF_n = 1'b0;
        tick();
        checks++; if ({bus_if.oRD_GNT, bus_if.oWR_GNT} !== 2'b10) begin errors++; $display("FAIL mid_reset_regrant got rd/wr %b want 10", {bus_if.oRD_GNT, bus_if.oWR_GNT}); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle_inputs();
        test_reset();
        test_first_tie();
`ifdef FTDI_FIFO_ARBITER_BURST_EN
        test_burst_release();
        test_burst_alone();
`else
        test_alternate();
`endif
        test_single_release();
        test_flag_hold();
        test_txe_wait();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/ftdi_fifo_arbiter.md
FTDI_FIFO_ARBITER -- requirements
Module: ftdi_fifo_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 8, meaning the maximum transfers per grant while the other side is eligible (range 1..255).
REQ-002 The block SHALL have parameter TURN_CYCLES, default 2, meaning the idle bus cycles between consecutive grants (range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, 50 MHz.
REQ-004 The block SHALL have port rst, input, 1 bit: reset; one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port iRD_REQ, input, 1 bit: read requester wants the FTDI bus.
REQ-006 The block SHALL have port iWR_REQ, input, 1 bit: write requester wants the FTDI bus.
REQ-007 The block SHALL have port iRD_DONE_n, input, 1 bit: one-cycle low pulse marking one completed read byte.
REQ-008 The block SHALL have port iWR_DONE_n, input, 1 bit: one-cycle low pulse marking one completed write byte.
REQ-009 The block SHALL have port iFIFO_RXF_n, input, 1 bit: FTDI receive data available, active low.
REQ-010 The block SHALL have port iFIFO_TXE_n, input, 1 bit: FTDI transmit space available, active low.
REQ-011 The block SHALL have port oRD_GNT, output, 1 bit: read requester owns the bus.
REQ-012 The block SHALL have port oWR_GNT, output, 1 bit: write requester owns the bus.
REQ-013 The block SHALL have port oBUS_OE, output, 1 bit: FPGA drives the FTDI data bus.
REQ-014 The block SHALL have port oBUSY, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 Eligibility SHALL be defined as follows: read is eligible when iRD_REQ=1 and iFIFO_RXF_n=0; write is eligible when iWR_REQ=1 and iFIFO_TXE_n=0.
REQ-016 The state machine SHALL have exactly four states: IDLE, RD_OWN, WR_OWN, TURN.
REQ-017 In IDLE, an eligible request sampled at edge N SHALL enter the matching OWN state, with its grant high after edge N; latency is 1 clock.
REQ-018 When both are eligible in IDLE, the side not served last SHALL win (round-robin); a single lastserved flag SHALL be updated on every grant.
REQ-019 All outputs SHALL be registered; oRD_GNT and oWR_GNT SHALL never be high simultaneously.
REQ-020 oBUS_OE SHALL equal oWR_GNT cycle for cycle and SHALL be 0 in IDLE, RD_OWN and TURN.
REQ-021 In an OWN state, each DONE_n low pulse from the owner SHALL increment an 8-bit burst counter; the counter SHALL be cleared on entry to an OWN state and SHALL saturate at 255.
REQ-022 An OWN state SHALL be left for TURN if the owner's REQ is 0, or if a DONE pulse brings the count to MAX_BURST while the other side is eligible.
REQ-023 The owner's FIFO flag deasserting SHALL NOT revoke the grant; the requester ends its transfer and drops REQ.
REQ-024 A DONE pulse and a REQ drop in the same cycle SHALL cause a single release.
REQ-025 A DONE pulse from the non-owner SHALL be ignored.
REQ-026 TURN SHALL hold both grants low for exactly TURN_CYCLES clocks, counted by a 4-bit counter, and then enter IDLE.
REQ-027 When the count reaches MAX_BURST and the other side is not eligible, the owner SHALL keep the grant and the counter SHALL continue counting.

Reset
REQ-028 While rst=0 at a clock edge, the block SHALL set state=IDLE, oRD_GNT=0, oWR_GNT=0, oBUS_OE=0, oBUSY=0, both counters=0 and lastserved=WRITE, so that read wins the first tie.
REQ-029 Reset asserted mid-grant SHALL drop all grants at that edge with no TURN phase.

Configuration
REQ-030 With macro FTDI_FIFO_ARBITER_BURST_EN defined, burst counting SHALL operate per REQ-021, REQ-022 and REQ-027; without it, every owner DONE pulse SHALL force release to TURN and the burst counter SHALL not be implemented.

Verification
REQ-031 The bench SHALL cover: reset, then both eligible at cycle 5 -> oRD_GNT=1 at cycle 6, oWR_GNT=0, oBUS_OE=0.
REQ-032 The bench SHALL cover: read owner with write eligible, 8 DONE pulses -> oRD_GNT=0 after the 8th pulse, 2 idle cycles, then oWR_GNT=1 and oBUS_OE=1.
REQ-033 The bench SHALL cover: write owner alone, 20 DONE pulses -> oWR_GNT stays 1 throughout.
REQ-034 The bench SHALL cover: iWR_REQ=1 with iFIFO_TXE_n=1 -> no grant; TXE_n falls at cycle 10 -> oWR_GNT=1 at cycle 11.
REQ-035 The bench SHALL cover: rst=0 while oWR_GNT=1 -> all outputs 0 after that edge.
REQ-036 The bench SHALL cover: without FTDI_FIFO_ARBITER_BURST_EN, both requesting -> grants alternate RD, WR, RD per single DONE pulse, with 2-cycle gaps.
